// File: rtl/tg2_csr_pkg.sv
// Shared types and limits for the TG2 CSR-side run monitor.
package tg2_csr_pkg;

    // Per-channel run monitor states.
    typedef enum logic [1:0] {
        MON_IDLE,
        MON_RUN,
        MON_DONE
    } t_tg_mon_state;

    // Widest supported counter value; narrower counters use its low bits.
    localparam logic [63:0] MON_CNT_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mem_tg2_status_mon_if.sv
// Bundle between the CSR block / TG2 engines and the status monitor.
// master: CSR/engine side driving run levels and raw results.
// slave:  monitor side returning latched flags and run clock counts.
interface mem_tg2_status_mon_if #(
    parameter int NUM_TG = 4
);
    logic [NUM_TG-1:0] mem_tg_active;
    logic [NUM_TG-1:0] tg_pass_in;
    logic [NUM_TG-1:0] tg_fail_in;
    logic [NUM_TG-1:0] tg_pass;
    logic [NUM_TG-1:0] tg_fail;
    logic [NUM_TG-1:0] tg_timeout;
    logic [63:0]       clock_count [NUM_TG];

    modport master (
        output mem_tg_active,
        output tg_pass_in,
        output tg_fail_in,
        input  tg_pass,
        input  tg_fail,
        input  tg_timeout,
        input  clock_count
    );

    modport slave (
        input  mem_tg_active,
        input  tg_pass_in,
        input  tg_fail_in,
        output tg_pass,
        output tg_fail,
        output tg_timeout,
        output clock_count
    );
endinterface

// File: rtl/mem_tg2_chan_mon.sv
// One TG channel: start detect, run-clock counter, result latch and watchdog.
module mem_tg2_chan_mon
    import tg2_csr_pkg::*;
#(
    parameter int          CNT_W          = 64,
    parameter logic [63:0] TIMEOUT_CYCLES = 64'h0000_0001_0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic        pass_in,
    input  logic        fail_in,
    output logic        tg_pass,
    output logic        tg_fail,
    output logic        tg_timeout,
    output logic [63:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = MON_CNT_MAX[CNT_W-1:0];
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 64'd0);
    localparam logic [63:0]      TO_LAST = TIMEOUT_CYCLES - 64'd1;

    t_tg_mon_state    state;
    logic             active_q;
    logic [CNT_W-1:0] cnt;
    logic             start;
    logic             term;
    logic             to_hit;

    // Counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Rising edge of the CSR run level, raw result and watchdog match.
    always_comb begin
        start  = active & ~active_q;
        term   = pass_in | fail_in;
        to_hit = TO_EN && (64'(cnt) == TO_LAST);
    end

    // Channel FSM with registered counter and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MON_IDLE;
            active_q   <= 1'b0;
            cnt        <= '0;
            tg_pass    <= 1'b0;
            tg_fail    <= 1'b0;
            tg_timeout <= 1'b0;
        end else begin
            active_q <= active;
            case (state)
                MON_IDLE, MON_DONE: begin
                    // Raw inputs are ignored here, even on the start cycle.
                    if (start) begin
                        state      <= MON_RUN;
                        cnt        <= '0;
                        tg_pass    <= 1'b0;
                        tg_fail    <= 1'b0;
                        tg_timeout <= 1'b0;
                    end
                end
                MON_RUN: begin
                    if (!active) begin
                        // Abort: counter frozen, flags untouched.
                        state <= MON_IDLE;
                    end else begin
                        cnt <= sat_inc(cnt);
                        if (term) begin
                            // A real result wins over a coincident watchdog hit.
                            state   <= MON_DONE;
                            tg_pass <= pass_in;
                            tg_fail <= fail_in;
                        end else if (to_hit) begin
                            state      <= MON_DONE;
                            tg_timeout <= 1'b1;
                        end
                    end
                end
                default: state <= MON_IDLE;
            endcase
        end
    end

    assign count = 64'(cnt);

endmodule

// File: rtl/mem_tg2_status_mon.sv
// Per-channel TG2 run monitor feeding the CSR pass/fail/timeout/clock_count inputs.
module mem_tg2_status_mon
    import tg2_csr_pkg::*;
#(
    parameter int          NUM_TG         = 4,
    parameter int          CNT_W          = 64,
    parameter logic [63:0] TIMEOUT_CYCLES = 64'h0000_0001_0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    mem_tg2_status_mon_if.slave         bus
);

    logic [NUM_TG-1:0] pass_w;
    logic [NUM_TG-1:0] fail_w;
    logic [NUM_TG-1:0] timeout_w;
    logic [63:0]       count_w [NUM_TG];

    // One independent monitor per channel.
    for (genvar g = 0; g < NUM_TG; g++) begin : g_chan
        mem_tg2_chan_mon #(
            .CNT_W          (CNT_W),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .active     (bus.mem_tg_active[g]),
            .pass_in    (bus.tg_pass_in[g]),
            .fail_in    (bus.tg_fail_in[g]),
            .tg_pass    (pass_w[g]),
            .tg_fail    (fail_w[g]),
            .tg_timeout (timeout_w[g]),
            .count      (count_w[g])
        );
        assign bus.clock_count[g] = count_w[g];
    end

    assign bus.tg_pass    = pass_w;
    assign bus.tg_fail    = fail_w;
    assign bus.tg_timeout = timeout_w;

endmodule

// File: tb/tb_mem_tg2_status_mon.sv
// Directed bench for mem_tg2_status_mon: start/pass, watchdog, dual result,
// abort, reset and counter saturation.
module tb_mem_tg2_status_mon;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_tg2_status_mon_if #(.NUM_TG(4)) bus ();
    mem_tg2_status_mon_if #(.NUM_TG(4)) bus_sat ();

    mem_tg2_status_mon #(
        .NUM_TG         (4),
        .CNT_W          (64),
        .TIMEOUT_CYCLES (64'd16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_tg2_status_mon #(
        .NUM_TG         (4),
        .CNT_W          (4),
        .TIMEOUT_CYCLES (64'd0)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.mem_tg_active     = '0;
        bus.tg_pass_in        = '0;
        bus.tg_fail_in        = '0;
        bus_sat.mem_tg_active = '0;
        bus_sat.tg_pass_in    = '0;
        bus_sat.tg_fail_in    = '0;

        // Reset state
        rst = 1'b1;
        tick(2);
        chk("rst_pass", 64'(bus.tg_pass), 64'd0);
        chk("rst_fail", 64'(bus.tg_fail), 64'd0);
        chk("rst_timeout", 64'(bus.tg_timeout), 64'd0);
        for (int c = 0; c < 4; c++) chk($sformatf("rst_cnt%0d", c), bus.clock_count[c], 64'd0);
        rst = 1'b0;
        tick();

        // ch0: start, pass pulse on the 10th RUN cycle
        bus.mem_tg_active[0] = 1'b1;
        tick();
        chk("c0_cnt_start", bus.clock_count[0], 64'd0);
        tick(9);
        chk("c0_cnt9", bus.clock_count[0], 64'd9);
        chk("c0_pass_pre", 64'(bus.tg_pass[0]), 64'd0);
        bus.tg_pass_in[0] = 1'b1;
        tick();
        bus.tg_pass_in[0] = 1'b0;
        chk("c0_pass", 64'(bus.tg_pass[0]), 64'd1);
        chk("c0_cnt", bus.clock_count[0], 64'd10);
        chk("c0_fail", 64'(bus.tg_fail[0]), 64'd0);
        chk("c0_timeout", 64'(bus.tg_timeout[0]), 64'd0);
        bus.mem_tg_active[0] = 1'b0;
        bus.tg_fail_in[0]    = 1'b1;
        tick(3);
        bus.tg_fail_in[0]    = 1'b0;
        chk("c0_hold_pass", 64'(bus.tg_pass[0]), 64'd1);
        chk("c0_hold_fail", 64'(bus.tg_fail[0]), 64'd0);
        chk("c0_hold_cnt", bus.clock_count[0], 64'd10);

        // ch1: watchdog at 16 clocks
        bus.mem_tg_active[1] = 1'b1;
        tick();
        tick(15);
        chk("c1_cnt15", bus.clock_count[1], 64'd15);
        chk("c1_to_pre", 64'(bus.tg_timeout[1]), 64'd0);
        tick();
        chk("c1_timeout", 64'(bus.tg_timeout[1]), 64'd1);
        chk("c1_cnt16", bus.clock_count[1], 64'd16);
        tick(3);
        chk("c1_hold_cnt", bus.clock_count[1], 64'd16);
        // drop active and restart
        bus.mem_tg_active[1] = 1'b0;
        tick();
        chk("c1_done_hold", 64'(bus.tg_timeout[1]), 64'd1);
        bus.mem_tg_active[1] = 1'b1;
        tick();
        chk("c1_restart_to", 64'(bus.tg_timeout[1]), 64'd0);
        chk("c1_restart_cnt", bus.clock_count[1], 64'd0);
        // term on the exact timeout cycle
        tick(15);
        bus.tg_fail_in[1] = 1'b1;
        tick();
        bus.tg_fail_in[1] = 1'b0;
        chk("c1_term_to", 64'(bus.tg_timeout[1]), 64'd0);
        chk("c1_term_fail", 64'(bus.tg_fail[1]), 64'd1);
        chk("c1_term_pass", 64'(bus.tg_pass[1]), 64'd0);
        chk("c1_term_cnt", bus.clock_count[1], 64'd16);

        // ch2: pass and fail together
        bus.mem_tg_active[2] = 1'b1;
        tick();
        tick(3);
        bus.tg_pass_in[2] = 1'b1;
        bus.tg_fail_in[2] = 1'b1;
        tick();
        bus.tg_pass_in[2] = 1'b0;
        bus.tg_fail_in[2] = 1'b0;
        chk("c2_pass", 64'(bus.tg_pass[2]), 64'd1);
        chk("c2_fail", 64'(bus.tg_fail[2]), 64'd1);
        chk("c2_timeout", 64'(bus.tg_timeout[2]), 64'd0);
        chk("c2_cnt", bus.clock_count[2], 64'd4);
        tick(20);
        chk("c2_done_cnt", bus.clock_count[2], 64'd4);
        chk("c2_done_to", 64'(bus.tg_timeout[2]), 64'd0);

        // ch3: abort at count 5, later pass ignored
        bus.mem_tg_active[3] = 1'b1;
        tick();
        tick(5);
        chk("c3_cnt5", bus.clock_count[3], 64'd5);
        bus.mem_tg_active[3] = 1'b0;
        tick();
        chk("c3_abort_cnt", bus.clock_count[3], 64'd5);
        bus.tg_pass_in[3] = 1'b1;
        tick(2);
        bus.tg_pass_in[3] = 1'b0;
        chk("c3_abort_pass", 64'(bus.tg_pass[3]), 64'd0);
        chk("c3_abort_fail", 64'(bus.tg_fail[3]), 64'd0);
        chk("c3_abort_to", 64'(bus.tg_timeout[3]), 64'd0);
        chk("c3_abort_cnt2", bus.clock_count[3], 64'd5);
        // start and pass in the same cycle: pass honoured only from RUN
        bus.mem_tg_active[3] = 1'b1;
        bus.tg_pass_in[3]    = 1'b1;
        tick();
        chk("c3_st_pass", 64'(bus.tg_pass[3]), 64'd0);
        chk("c3_st_cnt", bus.clock_count[3], 64'd0);
        tick();
        bus.tg_pass_in[3] = 1'b0;
        chk("c3_run_pass", 64'(bus.tg_pass[3]), 64'd1);
        chk("c3_run_cnt", bus.clock_count[3], 64'd1);

        // reset clears latched flags
        bus.mem_tg_active = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_pass", 64'(bus.tg_pass), 64'd0);
        chk("rst2_fail", 64'(bus.tg_fail), 64'd0);
        chk("rst2_timeout", 64'(bus.tg_timeout), 64'd0);
        chk("rst2_cnt1", bus.clock_count[1], 64'd0);

        // staggered starts, independent counts, then reset mid-run
        bus.mem_tg_active[3] = 1'b1;
        tick(4);
        bus.mem_tg_active[2] = 1'b1;
        tick(4);
        bus.mem_tg_active[1] = 1'b1;
        tick(4);
        bus.mem_tg_active[0] = 1'b1;
        tick(4);
        chk("stag_cnt0", bus.clock_count[0], 64'd3);
        chk("stag_cnt1", bus.clock_count[1], 64'd7);
        chk("stag_cnt2", bus.clock_count[2], 64'd11);
        chk("stag_cnt3", bus.clock_count[3], 64'd15);
        rst = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) chk($sformatf("mid_rst_cnt%0d", c), bus.clock_count[c], 64'd0);
        chk("mid_rst_flags", 64'({bus.tg_pass, bus.tg_fail, bus.tg_timeout}), 64'd0);
        rst = 1'b0;
        bus.mem_tg_active = '0;
        tick();

        // 4-bit counter, watchdog disabled: saturates at 15
        bus_sat.mem_tg_active[0] = 1'b1;
        tick();
        tick(14);
        chk("sat_cnt14", bus_sat.clock_count[0], 64'd14);
        tick();
        chk("sat_cnt15", bus_sat.clock_count[0], 64'd15);
        tick(5);
        chk("sat_hold", bus_sat.clock_count[0], 64'd15);
        chk("sat_no_to", 64'(bus_sat.tg_timeout[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
